// File: rtl/simon_pkg.sv
// Shared colour codes and game states for the colour-memory game.
// Also imported by the display driver.
package simon_pkg;

    localparam logic [2:0] RED    = 3'd0;
    localparam logic [2:0] GREEN  = 3'd1;
    localparam logic [2:0] BLUE   = 3'd2;
    localparam logic [2:0] YELLOW = 3'd3;
    localparam logic [2:0] NULL   = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        EXTEND,
        GAP,
        SHOW,
        WAIT_IN,
        ROUND_OK,
        LOSE,
        GAME_OVER
    } state_t;

    function automatic logic [2:0] to_disp(input logic [1:0] c);
        return {1'b0, c};
    endfunction

endpackage

// File: rtl/simon_pattern_mem.sv
// Pattern storage: DEPTH x 2-bit registers, synchronous write, combinational read.
// Contents are not reset; the sequencer's len gates every read.
module simon_pattern_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_data
);

    logic [1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : 2'b00;

endmodule

// File: rtl/simon_round_sequencer.sv
// Colour-memory game controller: extend, play back, collect and check presses.
// Optional SIMON_PRESS_BEEP_EN adds a one-tick buzzer pulse on each correct press.
module simon_round_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int SHOW_TICKS = 30,
    parameter int GAP_TICKS  = 10,
    parameter int IN_TICKS   = 250,
    parameter int BUZZ_TICKS = 60
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     start,
    input  logic [1:0]               rnd,
    input  logic                     btn_valid,
    input  logic [1:0]               btn_color,
    output logic [2:0]               disp_color,
    output logic                     buzzer,
    output logic [$clog2(MAX_LEN):0] score,
    output logic                     busy,
    output logic                     game_over,
    output logic                     won
);

    localparam int AW   = $clog2(MAX_LEN);
    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int T1   = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int T2   = (IN_TICKS > BUZZ_TICKS) ? IN_TICKS : BUZZ_TICKS;
    localparam int TMAX = (T1 > T2) ? T1 : T2;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_SHOW  = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] T_GAP   = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] T_IN    = TW'(IN_TICKS - 1);
    localparam logic [TW-1:0] T_BUZZ  = TW'(BUZZ_TICKS - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    state_t        state;
    logic [TW-1:0] timer;
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic          echo;
    logic [1:0]    pat;
    logic          expire;
    logic          press_ok;
    logic          last;

    simon_pattern_mem #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (state == EXTEND),
        .wr_addr (len[AW-1:0]),
        .wr_data (rnd),
        .rd_addr (idx[AW-1:0]),
        .rd_data (pat)
    );

    assign expire   = tick && (timer == '0);
    assign press_ok = (btn_color == pat);
    assign last     = (idx == len - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            len        <= '0;
            idx        <= '0;
            echo       <= 1'b0;
            disp_color <= NULL;
            buzzer     <= 1'b0;
            score      <= '0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
            won        <= 1'b0;
        end else begin
            // The press echo lasts until the next tick; state actions below override.
            if (echo && tick) begin
                echo       <= 1'b0;
                disp_color <= NULL;
`ifdef SIMON_PRESS_BEEP_EN
                buzzer     <= 1'b0;
`endif
            end
            unique case (state)
                IDLE, GAME_OVER: begin
                    if (start) begin
                        state     <= EXTEND;
                        len       <= '0;
                        score     <= '0;
                        won       <= 1'b0;
                        game_over <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                EXTEND: begin
                    len   <= len + 1'b1;
                    idx   <= '0;
                    timer <= T_GAP;
                    state <= GAP;
                end
                GAP: begin
                    if (expire) begin
                        if (idx < len) begin
                            state      <= SHOW;
                            timer      <= T_SHOW;
                            disp_color <= to_disp(pat);
                        end else begin
                            state <= WAIT_IN;
                            idx   <= '0;
                            timer <= T_IN;
                        end
                    end else if (tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                SHOW: begin
                    if (expire) begin
                        idx        <= idx + 1'b1;
                        state      <= GAP;
                        timer      <= T_GAP;
                        disp_color <= NULL;
                    end else if (tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT_IN: begin
                    if (btn_valid && press_ok) begin
                        disp_color <= to_disp(btn_color);
                        echo       <= 1'b1;
`ifdef SIMON_PRESS_BEEP_EN
                        buzzer     <= 1'b1;
`endif
                        timer      <= T_IN;
                        if (last) state <= ROUND_OK;
                        else      idx   <= idx + 1'b1;
                    end else if (btn_valid || expire) begin
                        state  <= LOSE;
                        timer  <= T_BUZZ;
                        buzzer <= 1'b1;
                    end else if (tick) begin
                        timer <= timer - 1'b1;
                    end
                end
                ROUND_OK: begin
                    score <= score + 1'b1;
                    if (len == LEN_MAX) begin
                        state     <= GAME_OVER;
                        won       <= 1'b1;
                        game_over <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state <= EXTEND;
                    end
                end
                LOSE: begin
                    if (expire) begin
                        state     <= GAME_OVER;
                        buzzer    <= 1'b0;
                        game_over <= 1'b1;
                        busy      <= 1'b0;
                        won       <= 1'b0;
                    end else begin
                        buzzer <= 1'b1;
                        if (tick) timer <= timer - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_round_sequencer.sv
// Directed bench for simon_round_sequencer: a default-size game and a MAX_LEN=2 game
// share the same stimulus; expected values are hand-derived cycle counts.
module tb_simon_round_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b1;
    logic       start = 1'b0;
    logic [1:0] rnd = 2'd0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_color = 2'd0;

    logic [2:0] disp_color;
    logic       buzzer;
    logic [4:0] score;
    logic       busy;
    logic       game_over;
    logic       won;

    logic [2:0] d2_disp;
    logic       d2_buzzer;
    logic [1:0] d2_score;
    logic       d2_busy;
    logic       d2_game_over;
    logic       d2_won;

    int errors = 0;
    int checks = 0;

`ifdef SIMON_PRESS_BEEP_EN
    localparam int BEEP = 1;
`else
    localparam int BEEP = 0;
`endif

    simon_round_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .rnd        (rnd),
        .btn_valid  (btn_valid),
        .btn_color  (btn_color),
        .disp_color (disp_color),
        .buzzer     (buzzer),
        .score      (score),
        .busy       (busy),
        .game_over  (game_over),
        .won        (won)
    );

    simon_round_sequencer #(.MAX_LEN(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .rnd        (rnd),
        .btn_valid  (btn_valid),
        .btn_color  (btn_color),
        .disp_color (d2_disp),
        .buzzer     (d2_buzzer),
        .score      (d2_score),
        .busy       (d2_busy),
        .game_over  (d2_game_over),
        .won        (d2_won)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    // Leaves the game in GAP, one edge after EXTEND.
    task automatic start_game(input logic [1:0] r);
        rnd = r;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        cyc();
        btn_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_disp"}, 32'(disp_color), 4);
        chk({tag, "_buzz"}, 32'(buzzer), 0);
        chk({tag, "_score"}, 32'(score), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_over"}, 32'(game_over), 0);
        chk({tag, "_won"}, 32'(won), 0);
    endtask

    initial begin
        run(2);
        reset = 1'b0;
        chk_reset("rst");

        // Round 1: pattern {2}
        rnd = 2'd2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_extend", 32'(busy), 1);
        cyc();
        run(9);
        chk("gap_end", 32'(disp_color), 4);
        cyc();
        chk("show_start", 32'(disp_color), 2);
        run(29);
        chk("show_end", 32'(disp_color), 2);
        cyc();
        chk("show_off", 32'(disp_color), 4);
        run(10);
        chk("wait_busy", 32'(busy), 1);
        rnd = 2'd0;
        press(2'd2);
        chk("echo_r1", 32'(disp_color), 2);
        chk("nobeep_r1", 32'(buzzer), BEEP);
        cyc();
        chk("echo_off", 32'(disp_color), 4);
        chk("score_r1", 32'(score), 1);

        // Round 2: playback 2, NULL, 0; press during SHOW and start while busy
        cyc();
        run(10);
        chk("r2_show0", 32'(disp_color), 2);
        btn_valid = 1'b1;
        btn_color = 2'd3;
        cyc();
        btn_valid = 1'b0;
        run(29);
        chk("r2_gap", 32'(disp_color), 4);
        start = 1'b1;
        run(10);
        start = 1'b0;
        chk("r2_show1", 32'(disp_color), 0);
        chk("start_busy", 32'(score), 1);
        run(30);
        chk("r2_gap2", 32'(disp_color), 4);
        run(10);
        press(2'd2);
        chk("echo_r2a", 32'(disp_color), 2);
        cyc();
        press(2'd0);
        chk("echo_r2b", 32'(disp_color), 0);
        cyc();
        chk("score_r2", 32'(score), 2);
        chk("busy_r2", 32'(busy), 1);

        // Short game reaches MAX_LEN=2
        chk("win_over", 32'(d2_game_over), 1);
        chk("win_won", 32'(d2_won), 1);
        chk("win_score", 32'(d2_score), 2);
        chk("win_busy", 32'(d2_busy), 0);
        rnd = 2'd1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_score", 32'(d2_score), 0);
        chk("restart_busy", 32'(d2_busy), 1);
        chk("restart_won", 32'(d2_won), 0);

        // Round 3 playback, then reset mid-SHOW
        run(10);
        chk("r3_show", 32'(disp_color), 2);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_reset("rst_mid");

        // Wrong colour in round 2 with score 1
        start_game(2'd3);
        run(50);
        rnd = 2'd1;
        press(2'd3);
        cyc();
        chk("lose_r1", 32'(score), 1);
        cyc();
        run(90);
        press(2'd1);
        chk("lose_buzz_on", 32'(buzzer), 1);
        run(59);
        chk("lose_buzz_hold", 32'(buzzer), 1);
        chk("lose_not_over", 32'(game_over), 0);
        cyc();
        chk("lose_buzz_off", 32'(buzzer), 0);
        chk("lose_over", 32'(game_over), 1);
        chk("lose_won", 32'(won), 0);
        chk("lose_score", 32'(score), 1);
        chk("lose_busy", 32'(busy), 0);

        // Timeout after 250 ticks of no press
        start_game(2'd1);
        chk("ng_score", 32'(score), 0);
        run(50);
        run(249);
        chk("to_early", 32'(buzzer), 0);
        cyc();
        chk("to_lose", 32'(buzzer), 1);
        run(60);
        chk("to_over", 32'(game_over), 1);

        // Frozen tick, then a press on the expiry tick itself
        start_game(2'd1);
        tick = 1'b0;
        run(40);
        chk("freeze_disp", 32'(disp_color), 4);
        chk("freeze_busy", 32'(busy), 1);
        tick = 1'b1;
        run(50);
        run(249);
        press(2'd1);
        chk("exp_press_buzz", 32'(buzzer), BEEP);
        chk("exp_press_echo", 32'(disp_color), 1);
        cyc();
        chk("exp_press_score", 32'(score), 1);
        chk("exp_press_over", 32'(game_over), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
